// File: rtl/mem_req_sequencer_if.sv
// Request, core-memory-port and response signals of mem_req_sequencer.
// master = the sequencer itself, slave = requester / core / response consumer side.
interface mem_req_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_error;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready,
        output rsp_valid, rsp_rdata, rsp_error,
        input  rsp_ready
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready,
        input  rsp_valid, rsp_rdata, rsp_error,
        output rsp_ready
    );
endinterface

// File: rtl/mem_req_sequencer.sv
// Queues load/store requests, issues them one at a time to the core memory port, returns responses.
// Define MEM_REQ_TIMEOUT_EN to enable the per-transaction watchdog, rsp_error and err_count.
module mem_req_sequencer #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset_n,
    mem_req_sequencer_if.master bus,
    output logic                busy,
    output logic [7:0]          err_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WD_W  = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0]  WD_INIT = WD_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] FULL    = CNT_W'(DEPTH);

    // state | meaning
    // IDLE  | waiting for a queued request
    // ISSUE | strobe held to the core, watchdog running
    // RESP  | response offered until accepted
    // GAP   | one strobe-free cycle so the core's mem_ready can fall
    typedef enum logic [1:0] {IDLE, ISSUE, RESP, GAP} state_e;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } entry_t;

    entry_t             fifo_q [DEPTH];
    entry_t             head;
    state_e             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WD_W-1:0]    wdog_q, wdog_d;
    logic               mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic               rsp_valid_q, rsp_valid_d, rsp_error_q, rsp_error_d;
    logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic [7:0]         err_count_q, err_count_d;
    logic               req_ready_int, push, pop;

    assign req_ready_int = (count_q != FULL);
    assign push          = bus.req_valid && req_ready_int;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        wdog_d      = wdog_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
        err_count_d = err_count_q;
        pop         = 1'b0;
        head        = fifo_q[rd_ptr_q];

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop         = 1'b1;
                    rd_ptr_d    = rd_ptr_q + PTR_W'(1);
                    mem_read_d  = !head.write;
                    mem_write_d = head.write;
                    mem_addr_d  = head.addr;
                    mem_wdata_d = head.write ? head.wdata : '0;
                    wdog_d      = WD_INIT;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (wdog_q != '0) wdog_d = wdog_q - WD_W'(1);
                // A ready seen in the first strobe cycle belongs to the previous transaction.
                if (bus.mem_ready && (wdog_q != WD_INIT)) begin
                    rsp_rdata_d = mem_read_q ? bus.mem_rdata : '0;
                    rsp_error_d = 1'b0;
                    rsp_valid_d = 1'b1;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = RESP;
                end
`ifdef MEM_REQ_TIMEOUT_EN
                else if (wdog_q == '0) begin
                    rsp_rdata_d = '0;
                    rsp_error_d = 1'b1;
                    rsp_valid_d = 1'b1;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
                    state_d     = RESP;
                end
`endif
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = GAP;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wdog_q      <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wdog_q      <= wdog_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
            err_count_q <= err_count_d;
            if (push) fifo_q[wr_ptr_q] <= '{write: bus.req_write, addr: bus.req_addr, wdata: bus.req_wdata};
        end
    end

    assign bus.req_ready = req_ready_int;
    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_error = rsp_error_q;
    assign busy          = (state_q != IDLE) || (count_q != '0);
    assign err_count     = err_count_q;
endmodule

// File: tb/tb_mem_req_sequencer.sv
// Randomized scoreboard bench for mem_req_sequencer: a behavioural memory model predicts every
// response at acceptance time; a separate monitor checks issued strobes and delivered responses.
`timescale 1ns/1ps
module tb_mem_req_sequencer;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       busy;
    logic [7:0] err_count;

    mem_req_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_req_sequencer #(.DEPTH(4), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .busy      (busy),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
    } rsp_t;

    req_t        issue_q [$];
    rsp_t        exp_q [$];
    logic [31:0] ref_mem  [logic [31:0]];
    logic [31:0] core_mem [logic [31:0]];

    int tests_run = 0;
    int fails     = 0;
    bit stall     = 1'b0;
    bit hold_rsp  = 1'b0;
    int lat_max   = 0;
    int last_run  = 0;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: memory contents in request order; a response is known the moment a request is accepted.
    task automatic model_accept(input logic w, input logic [31:0] a, input logic [31:0] d, input bit to);
        req_t r;
        rsp_t e;
        r.write = w;
        r.addr  = a;
        r.wdata = w ? d : 32'h0;
        issue_q.push_back(r);
        if (to) begin
            e.rdata = 32'h0;
            e.error = 1'b1;
        end else if (w) begin
            ref_mem[a] = d;
            e.rdata = 32'h0;
            e.error = 1'b0;
        end else begin
            e.rdata = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
            e.error = 1'b0;
        end
        exp_q.push_back(e);
    endtask

    task automatic push_req(input logic w, input logic [31:0] a, input logic [31:0] d, input bit to);
        bit done;
        done          = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        for (int i = 0; i < 200 && !done; i++) begin
            if (bus.req_ready) begin
                model_accept(w, a, d, to);
                done = 1'b1;
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        if (!done) check("push_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_rsp(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (bus.rsp_valid) break;
            @(negedge clk);
        end
        if (i == budget) check(name, 64'd0, 64'd1);
    endtask

    task automatic drain(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) break;
        end
        if (i == budget) check(name, 64'd0, 64'd1);
        check({name, "_issue_left"}, 64'(issue_q.size()), 64'd0);
    endtask

    // Core memory port: mem_ready is a register one cycle behind the strobe it answers.
    initial begin
        bit prev_strobe;
        int wait_cnt;
        prev_strobe   = 1'b0;
        wait_cnt      = 0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                bus.mem_ready = 1'b0;
                prev_strobe   = 1'b0;
                wait_cnt      = 0;
                continue;
            end
            if (prev_strobe && !bus.mem_ready) begin
                if (wait_cnt != 0) wait_cnt--;
                else if (!stall) begin
                    bus.mem_ready = 1'b1;
                    if (bus.mem_write) core_mem[bus.mem_addr] = bus.mem_wdata;
                    else bus.mem_rdata = core_mem.exists(bus.mem_addr) ? core_mem[bus.mem_addr] : dflt(bus.mem_addr);
                end
            end else begin
                bus.mem_ready = 1'b0;
                if (!prev_strobe) wait_cnt = $urandom_range(0, lat_max);
            end
            prev_strobe = bus.mem_read | bus.mem_write;
        end
    end

    // Monitor: strobe shape and order, response stability and scoreboard comparison.
    initial begin
        int   run, low;
        bit   seen, prev_hold;
        req_t cur;
        rsp_t held, e;
        run = 0; low = 0; seen = 1'b0; prev_hold = 1'b0;
        cur = '0; held = '0;
        bus.rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                run = 0; low = 0; seen = 1'b0; prev_hold = 1'b0;
                bus.rsp_ready = 1'b0;
                continue;
            end
            check("strobe_exclusive", 64'(bus.mem_read & bus.mem_write), 64'd0);
            if (bus.mem_read | bus.mem_write) begin
                if (run == 0) begin
                    if (seen) check("strobe_gap_ge2", 64'(low >= 2), 64'd1);
                    seen = 1'b1;
                    if (issue_q.size() == 0) check("issue_unexpected", 64'd1, 64'd0);
                    else begin
                        cur = issue_q.pop_front();
                        check("issue_write", 64'(bus.mem_write), 64'(cur.write));
                        check("issue_wdata", 64'(bus.mem_wdata), 64'(cur.wdata));
                    end
                end
                check("issue_addr", 64'(bus.mem_addr), 64'(cur.addr));
                check("issue_read", 64'(bus.mem_read), 64'(!cur.write));
                run++;
                low = 0;
            end else begin
                if (run != 0) begin
                    last_run = run;
                    check("strobe_len_ge2", 64'(run >= 2), 64'd1);
                end
                run = 0;
                low++;
            end

            if (prev_hold) begin
                check("rsp_valid_held", 64'(bus.rsp_valid), 64'd1);
                check("rsp_rdata_held", 64'(bus.rsp_rdata), 64'(held.rdata));
                check("rsp_error_held", 64'(bus.rsp_error), 64'(held.error));
            end
            bus.rsp_ready = hold_rsp ? 1'b0 : ($urandom_range(0, 9) < 7);
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) check("rsp_unexpected", 64'd1, 64'd0);
                else begin
                    e = exp_q.pop_front();
                    check("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
                    check("rsp_error", 64'(bus.rsp_error), 64'(e.error));
                end
            end
            prev_hold  = bus.rsp_valid && !bus.rsp_ready;
            held.rdata = bus.rsp_rdata;
            held.error = bus.rsp_error;
        end
    end

    initial begin
        #600000;
        $display("FAIL global_timeout: time %0t, limit 600000", $time);
        $fatal(1);
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        reset_n       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_mem_read",  64'(bus.mem_read),  64'd0);
        check("rst_mem_write", 64'(bus.mem_write), 64'd0);
        check("rst_mem_addr",  64'(bus.mem_addr),  64'd0);
        check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        check("rst_rsp_error", 64'(bus.rsp_error), 64'd0);
        check("rst_err_count", 64'(err_count),     64'd0);
        check("rst_busy",      64'(busy),          64'd0);
        check("rst_req_ready", 64'(bus.req_ready), 64'd1);

        // Single load answered one cycle after the strobe.
        lat_max = 0;
        core_mem[32'h100] = 32'hDEAD_BEEF;
        ref_mem[32'h100]  = 32'hDEAD_BEEF;
        push_req(1'b0, 32'h100, 32'h0, 1'b0);
        wait_rsp("single_load_rsp_timeout", 20);
        @(negedge clk);
        check("single_load_strobe_cycles", 64'(last_run), 64'd2);
        drain("single_load_drain", 100);

        // Fill the FIFO behind a stalled transaction.
        lat_max = 2;
        stall   = 1'b1;
        for (int i = 0; i < 5; i++)
            push_req(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom, 1'b0);
        check("fill_req_ready_low", 64'(bus.req_ready), 64'd0);
        check("fill_busy", 64'(busy), 64'd1);
        check("fill_in_issue", 64'(bus.mem_read | bus.mem_write), 64'd1);
        stall = 1'b0;
        drain("fill_drain", 500);

        // Response backpressure while more requests queue up.
        lat_max  = 1;
        hold_rsp = 1'b1;
        push_req(1'b1, 32'h40, $urandom, 1'b0);
        wait_rsp("bp_first_rsp_timeout", 40);
        push_req(1'b0, 32'h40, 32'h0, 1'b0);
        push_req(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
            check("bp_no_strobe", 64'(bus.mem_read | bus.mem_write), 64'd0);
        end
        hold_rsp = 1'b0;
        drain("bp_drain", 300);

`ifdef MEM_REQ_TIMEOUT_EN
        // Store with no mem_ready at all.
        stall = 1'b1;
        push_req(1'b1, 32'h20, $urandom, 1'b1);
        wait_rsp("to_rsp_timeout", 60);
        @(negedge clk);
        check("to_strobe_cycles", 64'(last_run), 64'(TIMEOUT));
        check("to_err_count", 64'(err_count), 64'd1);
        stall = 1'b0;
        drain("to_drain", 100);
`endif

        // Reset while a transaction is in ISSUE with two more queued.
        stall = 1'b1;
        for (int i = 0; i < 3; i++)
            push_req(1'b0, 32'($urandom_range(0, 15)) << 2, 32'h0, 1'b0);
        @(negedge clk);
        check("rstmid_in_issue", 64'(bus.mem_read), 64'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check("rstmid_strobes", 64'(bus.mem_read | bus.mem_write), 64'd0);
        check("rstmid_busy", 64'(busy), 64'd0);
        check("rstmid_req_ready", 64'(bus.req_ready), 64'd1);
        check("rstmid_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        issue_q.delete();
        exp_q.delete();
        reset_n = 1'b1;
        stall   = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rstmid_no_rsp", 64'(bus.rsp_valid), 64'd0);
            check("rstmid_no_strobe", 64'(bus.mem_read | bus.mem_write), 64'd0);
        end

        // Random traffic over a small address set so loads hit earlier stores.
        lat_max = 4;
        for (int n = 0; n < 60; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            push_req(1'($urandom_range(0, 1)), 32'($urandom_range(0, 7)) << 2, $urandom, 1'b0);
        end
        drain("random_drain", 3000);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
